// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch sequencer: PC-driven memory reads into a small prefetch FIFO,
// with redirect, halt drain and fault states. Optional counters under FETCH_STATS_EN.
module imem_fetch_ctrl #(
    parameter int unsigned       ADDR_W      = 32,
    parameter int unsigned       DATA_W      = 32,
    parameter int unsigned       DEPTH_LOG2  = 10,
    parameter int unsigned       FIFO_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]        HALT_OPCODE = 6'h11
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
`ifdef FETCH_STATS_EN
    output logic [31:0]       stat_fetched,
    output logic [31:0]       stat_stall,
`endif
    output logic              halted,
    output logic              fault
);
    localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_FAULT} state_e;

    state_e                               state_q;
    logic [ADDR_W-1:0]                    pc_q;
    logic [PTR_W-1:0]                     wr_q, rd_q;
    logic                                 halted_q, fault_q;
    logic [FIFO_DEPTH-1:0][DATA_W-1:0]    data_q;
    logic [FIFO_DEPTH-1:0][ADDR_W-1:0]    pcbuf_q;

    logic [PTR_W-1:0] count;
    logic             empty, full, pop, push, in_range, is_halt, redir;

    assign count    = wr_q - rd_q;
    assign empty    = (wr_q == rd_q);
    assign full     = (count == PTR_W'(FIFO_DEPTH));
    assign pop      = !empty && instr_ready;
    assign in_range = ((pc_q >> DEPTH_LOG2) == '0);
    assign is_halt  = (mem_rdata[31:26] == HALT_OPCODE);
    assign redir    = redirect_valid && (state_q != S_HALTED);
    // A slot freed by this cycle's pop can be refilled in the same cycle.
    assign push     = (state_q == S_RUN) && !redirect_valid && in_range && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            wr_q     <= '0;
            rd_q     <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else if (redir) begin
            state_q <= S_RUN;
            pc_q    <= redirect_pc;
            rd_q    <= wr_q;
            fault_q <= 1'b0;
        end else begin
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            if (push) begin
                wr_q <= wr_q + PTR_W'(1);
                pc_q <= pc_q + ADDR_W'(1);
            end
            case (state_q)
                S_RUN: begin
                    if (!in_range) begin
                        state_q <= S_FAULT;
                        fault_q <= 1'b1;
                    end else if (push && is_halt) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if ((count - PTR_W'(pop)) == '0) begin
                        state_q  <= S_HALTED;
                        halted_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Payload storage needs no reset: the pointers alone define occupancy.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_q[IDX_W-1:0]]  <= mem_rdata;
            pcbuf_q[wr_q[IDX_W-1:0]] <= pc_q;
        end
    end

    assign mem_addr    = pc_q;
    assign instr_valid = !empty;
    assign instr_out   = empty ? '0 : data_q[rd_q[IDX_W-1:0]];
    assign instr_pc    = empty ? '0 : pcbuf_q[rd_q[IDX_W-1:0]];
    assign halted      = halted_q;
    assign fault       = fault_q;

`ifdef FETCH_STATS_EN
    logic [31:0] fetched_q, stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            if (push && fetched_q != '1)
                fetched_q <= fetched_q + 32'd1;
            if (!empty && !instr_ready && stall_q != '1)
                stall_q <= stall_q + 32'd1;
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_stall   = stall_q;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Self-checking bench for imem_fetch_ctrl: directed scenarios plus randomized traffic,
// compared every cycle against a queue-based reference model.
module tb_imem_fetch_ctrl;
    localparam int FD = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mem_addr, mem_rdata, instr_out, instr_pc, redirect_pc;
    logic        instr_valid, instr_ready, redirect_valid, halted, fault;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched, stat_stall;
`endif
    logic [31:0] mem [1024];

    assign mem_rdata = mem[mem_addr[9:0]];

    imem_fetch_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .instr_out(instr_out), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
`ifdef FETCH_STATS_EN
        .stat_fetched(stat_fetched), .stat_stall(stat_stall),
`endif
        .halted(halted), .fault(fault)
    );

    always #5 clk = ~clk;

    // Reference model state
    ent_t        q[$];
    logic [31:0] m_pc;
    bit          m_drain, m_halted, m_fault;
    int unsigned m_fetched, m_stall;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_word(int halt_chance);
        logic [31:0] w = $urandom;
        if (halt_chance > 0 && $urandom_range(0, halt_chance - 1) == 0) w[31:26] = 6'h11;
        else if (w[31:26] == 6'h11) w[31:26] = 6'h12;
        return w;
    endfunction

    task automatic model_reset();
        q.delete();
        m_pc = 32'h0; m_drain = 0; m_halted = 0; m_fault = 0;
        m_fetched = 0; m_stall = 0;
    endtask

    // One clock of behaviour, applied with the inputs that will be seen at the next edge.
    task automatic model_step(bit rdy, bit redir, logic [31:0] rpc);
        bit popped = (q.size() > 0) && rdy;
        if (q.size() > 0 && !rdy) m_stall++;
        if (redir && !m_halted) begin
            q.delete();
            m_pc = rpc; m_drain = 0; m_fault = 0;
        end else begin
            if (popped) void'(q.pop_front());
            if (!m_drain && !m_halted && !m_fault) begin
                if (m_pc >= 32'd1024) m_fault = 1;
                else if (q.size() < FD) begin
                    q.push_back('{pc: m_pc, ins: mem[m_pc[9:0]]});
                    m_fetched++;
                    if (mem[m_pc[9:0]][31:26] == 6'h11) m_drain = 1;
                    m_pc = m_pc + 32'd1;
                end
            end else if (m_drain && q.size() == 0) begin
                m_drain = 0; m_halted = 1;
            end
        end
    endtask

    task automatic check_outputs(string ph);
        logic [31:0] e_ins = '0, e_pc = '0;
        if (q.size() > 0) begin e_ins = q[0].ins; e_pc = q[0].pc; end
        chk({ph, ".valid"},  32'(instr_valid), 32'(q.size() > 0));
        chk({ph, ".instr"},  instr_out, e_ins);
        chk({ph, ".ipc"},    instr_pc, e_pc);
        chk({ph, ".addr"},   mem_addr, m_pc);
        chk({ph, ".halted"}, 32'(halted), 32'(m_halted));
        chk({ph, ".fault"},  32'(fault), 32'(m_fault));
`ifdef FETCH_STATS_EN
        chk({ph, ".sfetch"}, stat_fetched, m_fetched);
        chk({ph, ".sstall"}, stat_stall, m_stall);
`endif
    endtask

    // Called at a falling edge: check, drive, advance model, wait one cycle.
    task automatic cyc(string ph, bit rdy, bit redir, logic [31:0] rpc);
        check_outputs(ph);
        instr_ready = rdy; redirect_valid = redir; redirect_pc = rpc;
        model_step(rdy, redir, rpc);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
        model_reset();
        #1 check_outputs("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        instr_ready = 0; redirect_valid = 0; redirect_pc = '0;
        for (int i = 0; i < 1024; i++) mem[i] = rnd_word(0);
        mem[0] = 32'h20010005; mem[1] = 32'h20020003;
        mem[2] = 32'h00221820; mem[3] = 32'h44000000;
        @(negedge clk);

        // Straight-line program ending in halt
        do_reset();
        for (int i = 0; i < 8; i++) cyc("halt4", 1, 0, 0);
        chk("halt4.final", 32'(halted), 32'd1);

        // Backpressure from reset, then release
        mem[3] = 32'h00430820;
        do_reset();
        for (int i = 0; i < 10; i++) cyc("stall", 0, 0, 0);
        chk("stall.addr", mem_addr, 32'd4);
        chk("stall.head", instr_out, 32'h20010005);
        for (int i = 0; i < 10; i++) cyc("release", 1, 0, 0);

        // Redirect with a full FIFO holding PCs 5..8
        do_reset();
        for (int i = 0; i < 6; i++) cyc("fill", 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc("fill", 0, 0, 0);
        chk("preflush.head", instr_pc, 32'd5);
        chk("preflush.addr", mem_addr, 32'd9);
        cyc("redir", 1, 1, 32'h40);
        chk("flush.valid", 32'(instr_valid), 32'd0);
        for (int i = 0; i < 6; i++) cyc("post", 1, 0, 0);

        // Last word of memory, then fault, then recover
        cyc("r1023", 1, 1, 32'd1023);
        for (int i = 0; i < 5; i++) cyc("edge", 1, 0, 0);
        chk("edge.fault", 32'(fault), 32'd1);
        cyc("r0", 1, 1, 32'd0);
        chk("recover.fault", 32'(fault), 32'd0);
        for (int i = 0; i < 4; i++) cyc("resume", 1, 0, 0);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 40 && mem_addr !== 32'h10; i++) cyc("run10", $urandom_range(0, 1) == 1, 0, 0);
        chk("reach10", mem_addr, 32'h10);
        #2 rst = 1'b1;
        model_reset();
        #1 chk("midrst.valid", 32'(instr_valid), 32'd0);
        check_outputs("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc("restart", 1, 0, 0);

        // Halt at PC2 with toggling ready; redirect afterwards is ignored
        mem[2] = 32'h44000000;
        do_reset();
        for (int i = 0; i < 12; i++) cyc("drain", (i % 2) == 0, 0, 0);
        cyc("hredir", 1, 1, 32'h40);
        for (int i = 0; i < 3; i++) cyc("hold", 1, 0, 0);
        chk("hold.halted", 32'(halted), 32'd1);
        chk("hold.addr", mem_addr, 32'd3);

        // Randomized traffic
        rst = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = rnd_word(48);
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit          rd = $urandom_range(0, 3) != 0;
            bit          rv = $urandom_range(0, 15) == 0;
            logic [31:0] tgt;
            case ($urandom_range(0, 3))
                0, 1:    tgt = 32'($urandom_range(0, 1023));
                2:       tgt = 32'($urandom_range(1020, 1023));
                default: tgt = ($urandom_range(0, 1) == 1) ? 32'hFFFFFFFF : 32'($urandom_range(1024, 1031));
            endcase
            if (m_halted) begin
                do_reset();
                rv = 1; tgt = 32'($urandom_range(0, 1023));
            end
            cyc("rand", rd, rv, tgt);
        end
        check_outputs("end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
